llm_attack_chain: RTL and testbench

//  Parametrised successor to the destructor-machine controller. Drives a chain of STAGES attack levels from

---
 rtl/llm_attack_chain_if.sv | 32 +++
 rtl/llm_attack_chain.sv | 143 ++++++++++++++
 tb/tb_llm_attack_chain.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/llm_attack_chain_if.sv
// Command inputs and Moore status outputs of the attack-chain controller.
// The slave modport is the controller side; master is the driving front end.
interface llm_attack_chain_if #(
  parameter int STAGES     = 3,
  parameter int TW         = 6,
  parameter int MAX_DECEPT = 2
);
  localparam int LW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;
  localparam int CW = (MAX_DECEPT > 0) ? $clog2(MAX_DECEPT + 1) : 1;

  logic              green;
  logic              red;
  logic              yellow;
  logic [3:0]        current_state;
  logic [LW-1:0]     level;
  logic [STAGES-1:0] attack;
  logic              expansion;
  logic              deception_out;
  logic              fail;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     decept_count;

  modport master (
    output green, red, yellow,
    input  current_state, level, attack, expansion, deception_out, fail, timer, decept_count
  );

  modport slave (
    input  green, red, yellow,
    output current_state, level, attack, expansion, deception_out, fail, timer, decept_count
  );
endinterface

// File: rtl/llm_attack_chain.sv
// Attack-chain controller: LAY_LOW -> ATTACK levels 1..STAGES -> EXPANSION, with
// dwell-timed hops, a bounded number of DECEPTION windows, and terminal FAIL/EXPANSION.
module llm_attack_chain #(
  parameter int STAGES      = 3,
  parameter int TW          = 6,
  parameter int DWELL_FIRST = 20,
  parameter int DWELL_STAGE = 20,
  parameter int DWELL_LAST  = 10,
  parameter int DECEPT_LEN  = 15,
  parameter int MAX_DECEPT  = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  llm_attack_chain_if.slave  bus
);
  localparam int LW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;
  localparam int CW = (MAX_DECEPT > 0) ? $clog2(MAX_DECEPT + 1) : 1;

  localparam logic [TW-1:0] DF   = TW'(DWELL_FIRST);
  localparam logic [TW-1:0] DS   = TW'(DWELL_STAGE);
  localparam logic [TW-1:0] DL   = TW'(DWELL_LAST);
  localparam logic [TW-1:0] DLEN = TW'(DECEPT_LEN);
  localparam logic [TW-1:0] TMAX = '1;
  localparam logic [LW-1:0] TOP  = LW'(STAGES);
  localparam logic [CW-1:0] MAXD = CW'(MAX_DECEPT);

  typedef enum logic [3:0] {
    LAY_LOW   = 4'd0,
    DECEPTION = 4'd1,
    ATTACK    = 4'd2,
    FAIL      = 4'd4,
    EXPANSION = 4'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     level_q, level_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     count_q, count_d;
  logic [STAGES-1:0] attack_q, attack_d;
  logic              expansion_q, expansion_d;
  logic              deception_q, deception_d;
  logic              fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    count_d = count_q;
    case (state_q)
      LAY_LOW, ATTACK: begin
        if (bus.red) begin
          if (count_q < MAXD) begin
            state_d = DECEPTION;
            count_d = count_q + CW'(1);
          end else begin
            state_d = FAIL;
          end
        end else if (state_q == LAY_LOW) begin
          if (bus.green && !bus.yellow && timer_q >= DF) begin
            state_d = ATTACK;
            level_d = LW'(1);
          end
        end else if (bus.yellow) begin
          if (level_q == LW'(1)) begin
            state_d = LAY_LOW;
            level_d = '0;
          end else begin
            level_d = level_q - LW'(1);
          end
        end else if (bus.green) begin
          if (level_q < TOP && timer_q >= DS) begin
            level_d = level_q + LW'(1);
          end else if (level_q == TOP && timer_q >= DL) begin
            state_d = EXPANSION;
          end
        end
      end
      DECEPTION: begin
        // Window resolves on the registered timer; red at that moment is fatal.
        if (timer_q == DLEN) begin
          if (bus.red) begin
            state_d = FAIL;
          end else begin
            state_d = LAY_LOW;
            level_d = '0;
          end
        end
      end
      FAIL, EXPANSION: ;
      default: begin
        state_d = LAY_LOW;
        level_d = '0;
      end
    endcase

    if (state_d != state_q || level_d != level_q) begin
      timer_d = TW'(1);
    end else if (timer_q == TMAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    // Flags are computed from the next state so they come straight out of flops.
    attack_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      attack_d[i] = (state_d == ATTACK) && (level_d > LW'(i));
    end
    expansion_d = (state_d == EXPANSION);
    deception_d = (state_d == DECEPTION);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LAY_LOW;
      level_q     <= '0;
      timer_q     <= TW'(1);
      count_q     <= '0;
      attack_q    <= '0;
      expansion_q <= 1'b0;
      deception_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      attack_q    <= attack_d;
      expansion_q <= expansion_d;
      deception_q <= deception_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.level         = level_q;
  assign bus.timer         = timer_q;
  assign bus.decept_count  = count_q;
  assign bus.attack        = attack_q;
  assign bus.expansion     = expansion_q;
  assign bus.deception_out = deception_q;
  assign bus.fail          = fail_q;
endmodule

// File: tb/tb_llm_attack_chain.sv
// Directed table-driven bench for llm_attack_chain with default parameters
// (STAGES=3, TW=6, dwells 20/20/10, DECEPT_LEN=15, MAX_DECEPT=2).
module tb_llm_attack_chain;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  llm_attack_chain_if #(.STAGES(3), .TW(6), .MAX_DECEPT(2)) bus ();

  llm_attack_chain #(
    .STAGES(3), .TW(6), .DWELL_FIRST(20), .DWELL_STAGE(20),
    .DWELL_LAST(10), .DECEPT_LEN(15), .MAX_DECEPT(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string nm;
    bit    rst;
    bit    g, r, y;
    int    n;
    int    st, lv, atk, tm, cnt;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int st, input int lv, input int atk,
                         input int tm, input int cnt);
    chk({nm, ".state"},     int'(bus.current_state), st);
    chk({nm, ".level"},     int'(bus.level),         lv);
    chk({nm, ".attack"},    int'(bus.attack),        atk);
    chk({nm, ".timer"},     int'(bus.timer),         tm);
    chk({nm, ".count"},     int'(bus.decept_count),  cnt);
    chk({nm, ".expansion"}, int'(bus.expansion),     (st == 5) ? 1 : 0);
    chk({nm, ".deception"}, int'(bus.deception_out), (st == 1) ? 1 : 0);
    chk({nm, ".fail"},      int'(bus.fail),          (st == 4) ? 1 : 0);
  endtask

  task automatic set_in(input bit g, input bit r, input bit y);
    bus.green  = g;
    bus.red    = r;
    bus.yellow = y;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    set_in(0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    //             name        rst g r y  n    st lv atk tm cnt
    tbl[0]  = '{"reset",        1, 0,0,0, 0,   0, 0, 0,  1, 0};
    tbl[1]  = '{"ll_dwell",     0, 1,0,0, 19,  0, 0, 0, 20, 0};
    tbl[2]  = '{"to_l1",        0, 1,0,0, 1,   2, 1, 1,  1, 0};
    tbl[3]  = '{"l1_dwell",     0, 1,0,0, 19,  2, 1, 1, 20, 0};
    tbl[4]  = '{"to_l2",        0, 1,0,0, 1,   2, 2, 3,  1, 0};
    tbl[5]  = '{"yel_l2",       0, 1,0,1, 1,   2, 1, 1,  1, 0};
    tbl[6]  = '{"yel_l1",       0, 0,0,1, 1,   0, 0, 0,  1, 0};
    tbl[7]  = '{"back_l1",      0, 1,0,0, 20,  2, 1, 1,  1, 0};
    tbl[8]  = '{"red_l1",       0, 0,1,0, 1,   1, 1, 0,  1, 1};
    tbl[9]  = '{"dec_win",      0, 0,0,0, 14,  1, 1, 0, 15, 1};
    tbl[10] = '{"dec_clean",    0, 0,0,0, 1,   0, 0, 0,  1, 1};
    tbl[11] = '{"red_ll",       0, 0,1,0, 1,   1, 0, 0,  1, 2};
    tbl[12] = '{"dec2_clean",   0, 0,0,0, 15,  0, 0, 0,  1, 2};
    tbl[13] = '{"red_max",      0, 0,1,0, 1,   4, 0, 0,  1, 2};
    tbl[14] = '{"fail_hold",    0, 1,1,1, 5,   4, 0, 0,  6, 2};
    tbl[15] = '{"run_l1",       1, 1,0,0, 20,  2, 1, 1,  1, 0};
    tbl[16] = '{"run_l2",       0, 1,0,0, 20,  2, 2, 3,  1, 0};
    tbl[17] = '{"l2_dwell",     0, 1,0,0, 19,  2, 2, 3, 20, 0};
    tbl[18] = '{"run_l3",       0, 1,0,0, 1,   2, 3, 7,  1, 0};
    tbl[19] = '{"l3_dwell",     0, 1,0,0, 9,   2, 3, 7, 10, 0};
    tbl[20] = '{"to_exp",       0, 1,0,0, 1,   5, 3, 0,  1, 0};
    tbl[21] = '{"exp_hold",     0, 1,1,1, 3,   5, 3, 0,  4, 0};
    tbl[22] = '{"f_l1",         1, 1,0,0, 20,  2, 1, 1,  1, 0};
    tbl[23] = '{"f_red",        0, 0,1,0, 1,   1, 1, 0,  1, 1};
    tbl[24] = '{"f_red_win",    0, 0,1,0, 14,  1, 1, 0, 15, 1};
    tbl[25] = '{"f_fail",       0, 0,1,0, 1,   4, 1, 0,  1, 1};
    tbl[26] = '{"f_ignore",     0, 1,0,1, 4,   4, 1, 0,  5, 1};

    for (int i = 0; i < 27; i++) begin
      if (tbl[i].rst) do_reset();
      set_in(tbl[i].g, tbl[i].r, tbl[i].y);
      step(tbl[i].n);
      chk_all(tbl[i].nm, tbl[i].st, tbl[i].lv, tbl[i].atk, tbl[i].tm, tbl[i].cnt);
    end

    // Timer saturation in LAY_LOW
    do_reset();
    step(62);
    chk_all("sat62", 0, 0, 0, 63, 0);
    step(8);
    chk_all("sat70", 0, 0, 0, 63, 0);
    set_in(1, 0, 0);
    step(1);
    chk_all("sat_go", 2, 1, 1, 1, 0);

    // Reset asserted between edges clears outputs immediately
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 0);
    set_in(0, 0, 0);
    step(1);
    chk_all("rst_held", 0, 0, 0, 1, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // All three commands together at the level-2 dwell boundary
    set_in(1, 0, 0);
    step(20);
    step(20);
    step(19);
    chk_all("l2_bound", 2, 2, 3, 20, 0);
    set_in(1, 1, 1);
    step(1);
    chk_all("ryg_l2", 1, 2, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
